// File: rtl/gray_code_counter_pkg.sv
// Shared Gray-code helpers for the counter RTL and its reference model.
// Functions work on MAX_W bits; narrower values are zero-extended, which leaves the mapping unchanged.
package gray_pkg;

    localparam int MAX_W = 16;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bv);
        return bv ^ (bv >> 1);
    endfunction

    // Prefix XOR from the MSB down, same as the downstream converter.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gv);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = gv[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gv[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Gray code word stream with valid/ready handshake and terminal-count flag.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] g;
    logic             g_valid;
    logic             g_ready;
    logic             tc;

    modport master (
        output g,
        output g_valid,
        output tc,
        input  g_ready
    );

    modport slave (
        input  g,
        input  g_valid,
        input  tc,
        output g_ready
    );
endinterface

// File: rtl/gray_code_counter_bin_to_gray.sv
// Combinational binary-to-Gray XOR stage.
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray-code output, load, wrap flag and backpressure.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    gray_code_counter_if.master out_if,
    output logic [WIDTH-1:0] bin_q
);

    logic [WIDTH-1:0] g_p1;
    logic             vld_p1;
    logic             tc_p1;

    logic             space;
    logic             wrap;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] bin_mux;
    logic [WIDTH-1:0] gray_mux;

    always_comb begin
        space    = !vld_p1 || out_if.g_ready;
        bin_next = up_dn ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
        wrap     = up_dn ? (bin_q == '1) : (bin_q == '0);
        bin_mux  = load ? load_bin : bin_next;
    end

    bin_to_gray #(.WIDTH(WIDTH)) u_bin_to_gray (
        .bin  (bin_mux),
        .gray (gray_mux)
    );

    // Stage p1: output register; a stalled step is dropped, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            g_p1   <= '0;
            vld_p1 <= 1'b0;
            tc_p1  <= 1'b0;
        end else if (load) begin
            bin_q  <= load_bin;
            g_p1   <= gray_mux;
            vld_p1 <= 1'b1;
            tc_p1  <= 1'b0;
        end else if (en && space) begin
            bin_q  <= bin_next;
            g_p1   <= gray_mux;
            vld_p1 <= 1'b1;
            tc_p1  <= wrap;
        end else if (!en && vld_p1 && out_if.g_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_if.g       = g_p1;
    assign out_if.g_valid = vld_p1;
    assign out_if.tc      = tc_p1;

endmodule

// File: tb/tb_gray_code_counter.sv
// Randomised and directed bench for gray_code_counter with a count-level reference model.
module tb_gray_code_counter;
    import gray_pkg::*;

    localparam int W    = 4;
    localparam int NMOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin_q;

    gray_code_counter_if #(.WIDTH(W)) gif ();

    gray_code_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .out_if   (gif),
        .bin_q    (bin_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model at count level: value, pending flag, wrap flag, words awaiting acceptance.
    int       m_cnt = 0;
    bit       m_vld = 0;
    bit       m_tc  = 0;
    int       exp_q[$];
    logic [W-1:0] prev_g = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int g_as_count();
        return int'(gray2bin(MAX_W'(gif.g)));
    endfunction

    task automatic cyc(input logic r_st, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb, input logic rdy);
        bit acc;
        bit stepped;
        bit wrap;
        rst = r_st; en = e; up_dn = u; load = l; load_bin = lb; gif.g_ready = rdy;
        #1;
        acc     = m_vld && rdy;
        stepped = 0;
        if (!r_st && acc) begin
            if (exp_q.size() == 0) check("acc_queue_empty", 1, 0);
            else begin
                check("acc_word", g_as_count(), exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        if (r_st) begin
            m_cnt = 0; m_vld = 0; m_tc = 0; exp_q.delete();
        end else if (l) begin
            exp_q.delete();
            m_cnt = int'(lb); m_vld = 1; m_tc = 0;
            exp_q.push_back(m_cnt);
        end else if (e && (!m_vld || rdy)) begin
            wrap  = u ? (m_cnt == NMOD - 1) : (m_cnt == 0);
            m_cnt = (m_cnt + NMOD + (u ? 1 : -1)) % NMOD;
            m_vld = 1; m_tc = wrap; stepped = 1;
            exp_q.push_back(m_cnt);
        end else if (!e && acc) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        check("g_valid", gif.g_valid, m_vld);
        check("tc", gif.tc, m_tc);
        check("bin_q", bin_q, m_cnt);
        check("g_decode", g_as_count(), m_cnt);
        if (stepped) check("one_bit_change", $countones(gif.g ^ prev_g), 1);
        prev_g = gif.g;
    endtask

    logic [W-1:0] up_tbl [16];

    initial begin
        up_tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        rst = 1; en = 0; up_dn = 1; load = 0; load_bin = '0; gif.g_ready = 0;

        // Reset state.
        cyc(1, 0, 0, 0, 4'd0, 0);
        check("rst_g", gif.g, 4'b0000);
        check("rst_valid", gif.g_valid, 1'b0);

        // Count up 16 words through wrap.
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 1, 0, 4'd0, 1);
            check("up_seq", gif.g, up_tbl[i]);
            check("up_tc", gif.tc, (i == 15));
        end

        // Count down from reset.
        cyc(1, 0, 0, 0, 4'd0, 0);
        cyc(0, 1, 0, 0, 4'd0, 1);
        check("dn_first_g", gif.g, 4'b1000);
        check("dn_first_tc", gif.tc, 1'b1);
        cyc(0, 1, 0, 0, 4'd0, 1);
        check("dn_second_g", gif.g, 4'b1001);
        check("dn_second_tc", gif.tc, 1'b0);

        // Backpressure with en held.
        cyc(1, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 4'd0, 1);
        check("bp_pre_g", gif.g, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 4'd0, 0);
            check("bp_hold_g", gif.g, 4'b0010);
            check("bp_hold_bin", bin_q, 4'd3);
            check("bp_hold_vld", gif.g_valid, 1'b1);
        end
        cyc(0, 1, 1, 0, 4'd0, 1);
        check("bp_release_g", gif.g, 4'b0110);

        // Load over a stalled pending word.
        cyc(0, 1, 1, 1, 4'b1010, 0);
        check("ld_g", gif.g, 4'b1111);
        check("ld_bin", bin_q, 4'b1010);
        check("ld_tc", gif.tc, 1'b0);
        cyc(0, 1, 1, 0, 4'd0, 1);
        check("ld_step_g", gif.g, 4'b1110);

        // Reset while stalled with load asserted.
        cyc(0, 1, 1, 0, 4'd0, 0);
        cyc(1, 1, 1, 1, 4'b0111, 0);
        check("mid_rst_g", gif.g, 4'b0000);
        check("mid_rst_vld", gif.g_valid, 1'b0);
        check("mid_rst_tc", gif.tc, 1'b0);
        check("mid_rst_bin", bin_q, 4'd0);

        // Randomised traffic.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 39) == 0),
                W'($urandom),
                ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 4'd0, 1);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
